// File: rtl/pat_scan_engine_pkg.sv
// Shared constants and FSM state type for the pattern scan engine.
package pat_scan_engine_pkg;

    localparam logic [7:0] PAT_ADDR = 8'd32;
    localparam logic [7:0] CTB_ADDR = 8'd33;
    localparam logic [7:0] CTO_ADDR = 8'd34;
    localparam logic [7:0] CTS_ADDR = 8'd35;
    localparam int         NBYTES   = 32;
    localparam logic [4:0] LAST_IDX = 5'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_PAT = 3'd1,
        SCAN     = 3'd2,
        WR_CTB   = 3'd3,
        WR_CTO   = 3'd4,
        WR_CTS   = 3'd5,
        DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/pat_scan_engine_if.sv
// Start/done handshake plus single-port data-memory bus of the scan engine.
// req is sampled on a rising edge; done is a level that stays high until the next req.
interface pat_scan_engine_if;
    logic       req;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    modport master (
        input  req, mem_rd_data,
        output done, mem_addr, mem_wr_en, mem_wr_data
    );

    modport slave (
        output req, mem_rd_data,
        input  done, mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/pat_window_match.sv
// Counts 5-bit pattern hits inside one byte and across the previous-nibble/byte boundary.
module pat_window_match (
    input  logic [4:0] i_pat,
    input  logic [3:0] i_prev_nib,
    input  logic [7:0] i_byte,
    input  logic       i_first,
    output logic [2:0] o_in_cnt,
    output logic       o_any,
    output logic [2:0] o_cross_cnt
);
    logic [11:0] w_bits;
    logic [2:0]  w_in_cnt;
    logic [2:0]  w_cross_cnt;

    assign w_bits = {i_prev_nib, i_byte};

    // Crossing windows occupy w_bits[11:7] down to w_bits[8:4].
    always_comb begin
        w_in_cnt    = '0;
        w_cross_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            if (i_byte[k +: 5] == i_pat)
                w_in_cnt = w_in_cnt + 3'd1;
            if (!i_first && (w_bits[(k + 4) +: 5] == i_pat))
                w_cross_cnt = w_cross_cnt + 3'd1;
        end
    end

    assign o_in_cnt    = w_in_cnt;
    assign o_cross_cnt = w_cross_cnt;
    assign o_any       = (w_in_cnt != 3'd0);
endmodule

// File: rtl/pat_scan_engine.sv
// Scans mem[0..31] for the 5-bit pattern in mem[32] and writes three hit counts to mem[33..35].
module pat_scan_engine
    import pat_scan_engine_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    pat_scan_engine_if.master         bus,
    output state_t                    o_dbg_state
);
    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_pat;
    logic [4:0] r_idx;
    logic [3:0] r_nib;
    logic [7:0] r_ctb;
    logic [7:0] r_cto;
    logic [7:0] r_cts;

    logic [2:0] w_in_cnt;
    logic       w_any;
    logic [2:0] w_cross_cnt;

    pat_window_match u_match (
        .i_pat       (r_pat),
        .i_prev_nib  (r_nib),
        .i_byte      (bus.mem_rd_data),
        .i_first     (r_idx == 5'd0),
        .o_in_cnt    (w_in_cnt),
        .o_any       (w_any),
        .o_cross_cnt (w_cross_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_idx   <= '0;
            r_nib   <= '0;
            r_ctb   <= '0;
            r_cto   <= '0;
            r_cts   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE, DONE: begin
                    if (bus.req) begin
                        r_idx <= '0;
                        r_nib <= '0;
                        r_ctb <= '0;
                        r_cto <= '0;
                        r_cts <= '0;
                    end
                end
                LOAD_PAT: begin
                    r_pat <= bus.mem_rd_data[4:0];
                    r_idx <= '0;
                end
                SCAN: begin
                    r_ctb <= r_ctb + {5'd0, w_in_cnt};
                    r_cto <= r_cto + {7'd0, w_any};
                    r_cts <= r_cts + {5'd0, w_in_cnt} + {5'd0, w_cross_cnt};
                    r_nib <= bus.mem_rd_data[3:0];
                    r_idx <= r_idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from the state alone so reset clears them immediately.
    always_comb begin
        w_state_nxt     = r_state;
        bus.done        = 1'b0;
        bus.mem_addr    = 8'd0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 8'd0;
        case (r_state)
            IDLE:     if (bus.req) w_state_nxt = LOAD_PAT;
            LOAD_PAT: begin
                bus.mem_addr = PAT_ADDR;
                w_state_nxt  = SCAN;
            end
            SCAN: begin
                bus.mem_addr = {3'd0, r_idx};
                if (r_idx == LAST_IDX) w_state_nxt = WR_CTB;
            end
            WR_CTB: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = CTB_ADDR;
                bus.mem_wr_data = r_ctb;
                w_state_nxt     = WR_CTO;
            end
            WR_CTO: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = CTO_ADDR;
                bus.mem_wr_data = r_cto;
                w_state_nxt     = WR_CTS;
            end
            WR_CTS: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = CTS_ADDR;
                bus.mem_wr_data = r_cts;
                w_state_nxt     = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.req) w_state_nxt = LOAD_PAT;
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_pat_scan_engine.sv
// Bench for pat_scan_engine: memory model, bit-string reference counts, write scoreboard.
module tb_pat_scan_engine;
    import pat_scan_engine_pkg::*;

    logic       clk;
    logic       reset;
    state_t     dbg_state;
    logic [7:0] mem [0:255];

    logic [15:0] exp_q [$];
    int          total;
    int          bad;
    int          wr_cnt;

    pat_scan_engine_if bus ();

    pat_scan_engine dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.master),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: combinational read, write on the rising edge
    assign bus.mem_rd_data = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset && bus.mem_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d want no write",
                         bus.mem_addr, bus.mem_wr_data);
            end else begin
                check("write", {bus.mem_addr, bus.mem_wr_data}, exp_q.pop_front());
            end
        end
    end

    // reference: treat mem[0..31] as a 256-bit MSB-first string and count windows
    task automatic model(output logic [7:0] ctb, output logic [7:0] cto, output logic [7:0] cts);
        logic       bits [256];
        logic       hit  [32];
        logic [4:0] p;
        logic [4:0] v;
        int         n_b, n_o, n_s;
        n_b = 0; n_o = 0; n_s = 0;
        p = mem[32][4:0];
        for (int b = 0; b < 32; b++) begin
            hit[b] = 1'b0;
            for (int j = 0; j < 8; j++) bits[b*8 + j] = mem[b][7-j];
        end
        for (int i = 0; i <= 251; i++) begin
            v = '0;
            for (int t = 0; t < 5; t++) v = {v[3:0], bits[i+t]};
            if (v == p) begin
                n_s++;
                if ((i % 8) <= 3) begin
                    n_b++;
                    hit[i/8] = 1'b1;
                end
            end
        end
        for (int b = 0; b < 32; b++) if (hit[b]) n_o++;
        ctb = 8'(n_b); cto = 8'(n_o); cts = 8'(n_s);
    endtask

    // driver: one complete run with given expectations
    task automatic do_run(input logic [7:0] e_ctb, input logic [7:0] e_cto, input logic [7:0] e_cts,
                          input bit pulse_mid, input bit from_done);
        int lat;
        int wr_before;
        exp_q.push_back({CTB_ADDR, e_ctb});
        exp_q.push_back({CTO_ADDR, e_cto});
        exp_q.push_back({CTS_ADDR, e_cts});
        wr_before = wr_cnt;
        lat = 0;
        @(negedge clk) bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        if (from_done) check("done_fall", bus.done, 1'b0);
        for (int n = 1; n <= 80 && lat == 0; n++) begin
            if (pulse_mid) bus.req = (n == 15);
            @(posedge clk);
            #1;
            if (bus.done) lat = n;
        end
        bus.req = 1'b0;
        check("latency", lat, 36);
        check("write_count", wr_cnt - wr_before, 3);
        check("queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1 check("done_hold", bus.done, 1'b1);
    endtask

    task automatic fill_random(input bit dense);
        for (int b = 0; b < 32; b++)
            mem[b] = dense ? (($urandom_range(0, 1) != 0) ? 8'hFF : 8'(1 << $urandom_range(0, 7)))
                           : 8'($urandom);
        mem[32] = 8'($urandom);
    endtask

    task automatic run_random(input bit pulse_mid, input bit from_done, input bit dense);
        logic [7:0] c_b, c_o, c_s;
        fill_random(dense);
        model(c_b, c_o, c_s);
        do_run(c_b, c_o, c_s, pulse_mid, from_done);
    endtask

    initial begin
        logic [7:0] c_b, c_o, c_s;
        total = 0; bad = 0; wr_cnt = 0;
        bus.req = 1'b0;
        reset = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", bus.done, 1'b0);
        check("rst_wr_en", bus.mem_wr_en, 1'b0);
        check("rst_addr", bus.mem_addr, 8'd0);
        check("rst_wr_data", bus.mem_wr_data, 8'd0);
        check("rst_state", dbg_state, IDLE);
        @(negedge clk) reset = 1'b0;

        // all zero data, zero pattern: every window hits
        do_run(8'd128, 8'd32, 8'd252, 1'b0, 1'b0);
        // all zero data, pattern 11111: nothing hits
        mem[32] = 8'h1F;
        do_run(8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        // only a byte-crossing window matches
        mem[0] = 8'h0F; mem[1] = 8'h80;
        do_run(8'd0, 8'd0, 8'd1, 1'b0, 1'b1);
        // all ones, upper pattern bits ignored
        for (int b = 0; b < 32; b++) mem[b] = 8'hFF;
        mem[32] = 8'hFF;
        do_run(8'd128, 8'd32, 8'd252, 1'b0, 1'b1);

        // req pulsed mid-scan is ignored; a second run from DONE repeats the result
        fill_random(1'b1);
        model(c_b, c_o, c_s);
        do_run(c_b, c_o, c_s, 1'b1, 1'b1);
        do_run(c_b, c_o, c_s, 1'b0, 1'b1);

        // reset during SCAN at index 10 aborts with no writes
        fill_random(1'b0);
        @(negedge clk) bus.req = 1'b1;
        @(posedge clk);
        #1 bus.req = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid_state", dbg_state, SCAN);
        check("mid_addr", bus.mem_addr, 8'd10);
        begin
            int wr_before;
            wr_before = wr_cnt;
            reset = 1'b1;
            #1;
            check("abort_done", bus.done, 1'b0);
            check("abort_wr_en", bus.mem_wr_en, 1'b0);
            check("abort_addr", bus.mem_addr, 8'd0);
            check("abort_wr_data", bus.mem_wr_data, 8'd0);
            check("abort_state", dbg_state, IDLE);
            repeat (3) @(posedge clk);
            @(negedge clk) reset = 1'b0;
            repeat (40) @(posedge clk);
            #1;
            check("abort_no_writes", wr_cnt - wr_before, 0);
            check("abort_idle", dbg_state, IDLE);
        end
        run_random(1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) run_random(1'b0, 1'b1, r[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pat_scan_engine.md
PAT_SCAN_ENGINE -- requirements
Module: pat_scan_engine

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port req, input, 1, start request, sampled on a rising edge.
REQ-004 SHALL have port done, output, 1, high while results are written and engine is idle-complete.
REQ-005 SHALL have port mem_addr, output, 8, data-memory byte address.
REQ-006 SHALL have port mem_rd_data, input, 8, data-memory read data, combinational from mem_addr in the same cycle.
REQ-007 SHALL have port mem_wr_en, output, 1, data-memory write strobe, write taken at the rising edge.
REQ-008 SHALL have port mem_wr_data, output, 8, data-memory write data.

Function
REQ-009 SHALL read a 5-bit pattern P from mem[32][4:0]; mem[32][7:5] are ignored.
REQ-010 SHALL scan mem[0..31]; the string is byte 0 as most significant, bit 7 of each byte first.
REQ-011 SHALL compute CTB = number of (byte, k) with byte[k+4:k]==P, k in 0..3, over all 32 bytes (max 128).
REQ-012 SHALL compute CTO = number of bytes with at least one in-byte match (max 32).
REQ-013 SHALL compute CTS = matches over all 252 5-bit windows of the 256-bit string, including byte-crossing windows (max 252).
REQ-014 SHALL form crossing windows from the previous byte's bits [3:0] and the current byte: {p[3:0],c[7]}, {p[2:0],c[7:6]}, {p[1:0],c[7:5]}, {p[0],c[7:4]}; byte 0 has no crossing windows.
REQ-015 SHALL use 8-bit unsigned counters; no saturation is needed (all maxima < 256).
REQ-016 SHALL implement FSM states IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE.
REQ-017 IDLE: mem_addr=0, mem_wr_en=0; req=1 -> LOAD_PAT, clearing all counters.
REQ-018 LOAD_PAT: mem_addr=32, latch P; -> SCAN with index 0.
REQ-019 SCAN: mem_addr=index; accumulate one byte per cycle, latch byte[3:0] as previous nibble; index 31 -> WR_CTB.
REQ-020 WR_CTB/WR_CTO/WR_CTS: mem_wr_en=1, mem_addr=33/34/35, mem_wr_data=CTB/CTO/CTS respectively, one cycle each, in that order.
REQ-021 DONE: done=1, mem_wr_en=0; req=1 -> LOAD_PAT (restart, done falls next cycle); otherwise hold.
REQ-022 done SHALL rise 36 rising edges after the edge that samples req in IDLE or DONE.
REQ-023 req SHALL be ignored in LOAD_PAT, SCAN and WR_* states.
REQ-024 mem_wr_en SHALL be high only in WR_* states, exactly 3 cycles per run.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, counters/P/index/nibble=0.
REQ-026 reset mid-run SHALL abort without further writes; a later req SHALL produce a full correct run.

Structure
REQ-027 A shared package SHALL hold PAT_ADDR=32, CTB_ADDR=33, CTO_ADDR=34, CTS_ADDR=35, NBYTES=32, and the FSM state enum.
REQ-028 SHALL instantiate one combinational sub-module pat_window_match (inputs P, prev nibble, byte, first flag; outputs in-byte count 0..4, any-match flag, crossing count 0..4).

Verification
REQ-029 All bytes 0x00, mem[32]=0x00 -> mem[33]=128, mem[34]=32, mem[35]=252.
REQ-030 All bytes 0x00, mem[32]=0x1F -> 0, 0, 0.
REQ-031 byte0=0x0F, byte1=0x80, rest 0x00, mem[32]=0x1F -> 0, 0, 1 (crossing-only match).
REQ-032 All bytes 0xFF, mem[32]=0xFF (P=0x1F) -> 128, 32, 252; done rises exactly 36 edges after req.
REQ-033 Reset asserted in SCAN at index 10 -> outputs at reset values that cycle, no writes; re-req with random data matches a reference model.
REQ-034 req pulsed during SCAN -> no restart, results unchanged; req in DONE -> second run with identical results.
